// File: rtl/m_cache_assoc_pkg.sv
// Shared address defines, legal configuration constants and replacement helpers
// for the set-associative cache.
`ifndef M_CACHE_ASSOC_PKG_SV
`define M_CACHE_ASSOC_PKG_SV

`define EADDR_WIDTH 32
`define EADDR [`EADDR_WIDTH-1:0]
`define M_CACHE_LEGAL_WAYS(w)  ((w) == 1 || (w) == 2 || (w) == 4)
`define M_CACHE_LEGAL_WORDS(n) ((n) == 2 || (n) == 4 || (n) == 8)

package m_cache_assoc_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int PLRU_W = 3;

  // 2-way: st[0] names the LRU way. 4-way: st[0] picks the half, st[1]/st[2] the way.
  function automatic logic [1:0] plru_victim(input logic [PLRU_W-1:0] st, input int ways);
    if (ways == 4)      plru_victim = st[0] ? {1'b1, st[2]} : {1'b0, st[1]};
    else if (ways == 2) plru_victim = {1'b0, st[0]};
    else                plru_victim = 2'd0;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] st,
                                                   input logic [1:0] way, input int ways);
    plru_touch = st;
    if (ways == 4) begin
      plru_touch[0] = ~way[1];
      if (way[1]) plru_touch[2] = ~way[0];
      else        plru_touch[1] = ~way[0];
    end else if (ways == 2) begin
      plru_touch[0] = ~way[0];
    end
  endfunction

endpackage

`endif

// File: rtl/m_cache_plru.sv
// Per-set replacement state: victim lookup, read-hit touch and install touch.
module m_cache_plru
  import m_cache_assoc_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int WAYS        = 2
) (
  input  logic                   i_clk,
  input  logic                   i_clr,
  input  logic [INDEX_WIDTH-1:0] i_clr_set,
  input  logic [INDEX_WIDTH-1:0] i_vic_set,
  output logic [1:0]             o_victim,
  input  logic                   i_hit,
  input  logic [INDEX_WIDTH-1:0] i_hit_set,
  input  logic [1:0]             i_hit_way,
  input  logic                   i_ins,
  input  logic [INDEX_WIDTH-1:0] i_ins_set,
  input  logic [1:0]             i_ins_way
);

  logic [PLRU_W-1:0] st_q [2**INDEX_WIDTH];
  logic [PLRU_W-1:0] hit_nx, ins_base;

  assign o_victim = plru_victim(st_q[i_vic_set], WAYS);

  // A same-set install lands on top of the read-hit touch so the install is most recent.
  always_comb begin
    hit_nx   = plru_touch(st_q[i_hit_set], i_hit_way, WAYS);
    ins_base = (i_hit && i_hit_set == i_ins_set) ? hit_nx : st_q[i_ins_set];
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      st_q[i_clr_set] <= '0;
    end else begin
      if (i_hit) st_q[i_hit_set] <= hit_nx;
      if (i_ins) st_q[i_ins_set] <= plru_touch(ins_base, i_ins_way, WAYS);
    end
  end

endmodule

// File: rtl/m_ram_1r1w.sv
// Single-word 1R1W store: synchronous read returning the pre-write contents.
module m_ram_1r1w #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/m_cache_assoc.sv
// Set-associative, write-through no-allocate line cache with an init sweep
// that clears valid bits and replacement state one set per cycle.
//   state    | meaning
//   ST_INIT  | sweeping set counter cnt_q, clearing valid and PLRU state
//   ST_READY | lookups, writes and installs enabled until reset
module m_cache_assoc
  import m_cache_assoc_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int WAYS        = 2,
  parameter int WORDS       = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic `EADDR                i_addr,
  output logic                       o_hit,
  input  logic                       i_we,
  input  logic [31:0]                i_data,
  output logic [32*WORDS-1:0]        o_data,
  output logic                       o_rhit,
  output logic [$clog2(WORDS)-1:0]   o_bindex,
  input  logic                       i_ie,
  input  logic `EADDR                i_iaddr,
  input  logic [32*WORDS-1:0]        i_idata,
  output logic                       o_ready,
  output logic                       o_err
);

  localparam int OW   = $clog2(WORDS);
  localparam int SETS = 1 << INDEX_WIDTH;
  localparam int TLSB = OW + 2 + INDEX_WIDTH;
  localparam int TW   = `EADDR_WIDTH - TLSB;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e                 state_q, state_nx;
  logic [INDEX_WIDTH-1:0] cnt_q;
  logic                   ready, clr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      if (clr) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_INIT: if (cnt_q == INDEX_WIDTH'(SETS - 1)) state_nx = ST_READY;
      default: state_nx = ST_READY;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_READY);
    clr   = (state_q == ST_INIT);
  end

  logic [OW-1:0]          widx;
  logic [INDEX_WIDTH-1:0] set, iset;
  logic [TW-1:0]          tag, itag;
  logic                   unused_bits;

  assign widx        = i_addr[OW+1:2];
  assign set         = i_addr[TLSB-1:OW+2];
  assign tag         = i_addr[`EADDR_WIDTH-1:TLSB];
  assign iset        = i_iaddr[TLSB-1:OW+2];
  assign itag        = i_iaddr[`EADDR_WIDTH-1:TLSB];
  assign unused_bits = ^{i_addr[1:0], i_iaddr[OW+1:0]};

  logic [TW-1:0]   tag_q [WAYS][SETS];
  logic [SETS-1:0] vld_q [WAYS];
  logic [WAYS-1:0] hitv, imatch, iinv;
  logic [WW-1:0]   hway, vic;
  logic [1:0]      plru_vic;
  logic            ins_fire, wr_fire, byp;

  // Victim priority: matching tag, then lowest invalid way, then PLRU.
  always_comb begin
    vic  = WW'(plru_vic);
    hway = '0;
    for (int w = 0; w < WAYS; w++) begin
      hitv[w]   = ready && vld_q[w][set] && (tag_q[w][set] == tag);
      imatch[w] = vld_q[w][iset] && (tag_q[w][iset] == itag);
      iinv[w]   = !vld_q[w][iset];
      if (hitv[w]) hway = WW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) if (iinv[w]) vic = WW'(w);
    for (int w = WAYS - 1; w >= 0; w--) if (imatch[w]) vic = WW'(w);
  end

  assign o_hit    = |hitv;
  assign ins_fire = ready && i_ie;
  assign wr_fire  = ready && i_we && !i_ie && o_hit;
  assign byp      = ins_fire && (iset == set) && (itag == tag);
  assign o_err    = !i_rst && ((i_we && i_ie) || (!ready && (i_we || i_ie)));
  assign o_ready  = ready;

  always_ff @(posedge i_clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (clr) begin
        vld_q[w][cnt_q] <= 1'b0;
      end else if (ins_fire && vic == WW'(w)) begin
        vld_q[w][iset] <= 1'b1;
        tag_q[w][iset] <= itag;
      end
    end
  end

  m_cache_plru #(.INDEX_WIDTH(INDEX_WIDTH), .WAYS(WAYS)) u_plru (
    .i_clk     (i_clk),
    .i_clr     (clr),
    .i_clr_set (cnt_q),
    .i_vic_set (iset),
    .o_victim  (plru_vic),
    .i_hit     (o_hit),
    .i_hit_set (set),
    .i_hit_way (2'(hway)),
    .i_ins     (ins_fire),
    .i_ins_set (iset),
    .i_ins_way (2'(vic))
  );

  logic [WAYS-1:0][32*WORDS-1:0] way_line;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    for (genvar k = 0; k < WORDS; k++) begin : g_word
      logic        we_wk;
      logic [31:0] wd_wk;
      assign we_wk = (ins_fire && vic == WW'(w)) ||
                     (wr_fire && hway == WW'(w) && widx == OW'(k));
      assign wd_wk = ins_fire ? i_idata[32*k +: 32] : i_data;
      m_ram_1r1w #(.DEPTH_LOG2(INDEX_WIDTH), .WIDTH(32)) u_ram (
        .i_clk   (i_clk),
        .i_we    (we_wk),
        .i_waddr (ins_fire ? iset : set),
        .i_wdata (wd_wk),
        .i_raddr (set),
        .o_rdata (way_line[w][32*k +: 32])
      );
    end
  end

  logic                rhit_q, byp_q, wbyp_q;
  logic [OW-1:0]       bidx_q;
  logic [WW-1:0]       hway_q;
  logic [32*WORDS-1:0] idata_q;
  logic [31:0]         wdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rhit_q <= 1'b0;
      bidx_q <= '0;
    end else begin
      rhit_q <= o_hit || byp;
      bidx_q <= widx;
    end
    hway_q  <= hway;
    byp_q   <= byp;
    wbyp_q  <= wr_fire;
    idata_q <= i_idata;
    wdata_q <= i_data;
  end

  // The stores return pre-write data, so same-cycle writes and installs are forwarded here.
  always_comb begin
    o_data = way_line[hway_q];
    if (wbyp_q) o_data[32*bidx_q +: 32] = wdata_q;
    if (byp_q)  o_data = idata_q;
  end

  assign o_rhit   = rhit_q;
  assign o_bindex = bidx_q;

endmodule

// File: tb/tb_m_cache_assoc.sv
// Scoreboard bench for m_cache_assoc (2 ways, 4 words, 64 sets).
module tb_m_cache_assoc;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [31:0]  i_addr = '0;
  logic         o_hit;
  logic         i_we = 1'b0;
  logic [31:0]  i_data = '0;
  logic [127:0] o_data;
  logic         o_rhit;
  logic [1:0]   o_bindex;
  logic         i_ie = 1'b0;
  logic [31:0]  i_iaddr = '0;
  logic [127:0] i_idata = '0;
  logic         o_ready;
  logic         o_err;

  always #5 i_clk = ~i_clk;

  m_cache_assoc #(.INDEX_WIDTH(6), .WAYS(2), .WORDS(4)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_addr   (i_addr),
    .o_hit    (o_hit),
    .i_we     (i_we),
    .i_data   (i_data),
    .o_data   (o_data),
    .o_rhit   (o_rhit),
    .o_bindex (o_bindex),
    .i_ie     (i_ie),
    .i_iaddr  (i_iaddr),
    .i_idata  (i_idata),
    .o_ready  (o_ready),
    .o_err    (o_err)
  );

  typedef struct packed {
    logic         rhit;
    logic [1:0]   bidx;
    logic [127:0] line;
  } exp_t;

  exp_t  sb_q[$];
  string sb_nm[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] base);
    mk_line = {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  function automatic logic [127:0] set_word(input logic [127:0] line, input int idx, input logic [31:0] val);
    set_word = line;
    set_word[32*idx +: 32] = val;
  endfunction

  // Registered read results, popped one cycle after the read was driven.
  always @(posedge i_clk) begin
    exp_t  e;
    string nm;
    #1;
    if (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      nm = sb_nm.pop_front();
      check_val({nm, "_rhit"}, o_rhit, e.rhit);
      if (e.rhit) begin
        check_val({nm, "_bindex"}, o_bindex, e.bidx);
        check_val({nm, "_data"}, o_data, e.line);
      end
    end
  end

  task automatic cyc(input string nm, input logic we, input logic [31:0] d, input logic [31:0] a,
                     input logic ie, input logic [31:0] ia, input logic [127:0] idt,
                     input int exp_hit, input logic exp_err,
                     input logic push, input logic exp_rhit, input logic [127:0] exp_line);
    i_we = we; i_data = d; i_addr = a; i_ie = ie; i_iaddr = ia; i_idata = idt;
    #1;
    if (exp_hit >= 0) check_val({nm, "_hit"}, o_hit, exp_hit[0]);
    check_val({nm, "_err"}, o_err, exp_err);
    if (push) begin
      sb_q.push_back('{rhit: exp_rhit, bidx: a[3:2], line: exp_line});
      sb_nm.push_back(nm);
    end
    @(negedge i_clk);
    i_we = 1'b0;
    i_ie = 1'b0;
  endtask

  task automatic reset_and_sweep(input string nm, input int ie_at, input int rst_at);
    int cnt;
    i_rst = 1'b1; i_we = 1'b0; i_ie = 1'b0; i_addr = 32'h00C;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    cnt = 0;
    while (o_ready !== 1'b1 && cnt < 200) begin
      if (cnt == rst_at) begin
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst  = 1'b0;
        cnt    = 0;
        rst_at = -1;
      end
      i_ie = (cnt == ie_at); i_iaddr = 32'h000; i_idata = mk_line(32'h5A5A0000);
      #1;
      if (cnt == 0) begin
        check_val({nm, "_rst_ready"}, o_ready, 1'b0);
        check_val({nm, "_rst_rhit"}, o_rhit, 1'b0);
        check_val({nm, "_rst_bindex"}, o_bindex, 2'd0);
      end
      if (cnt == ie_at) begin
        check_val({nm, "_init_err"}, o_err, 1'b1);
        check_val({nm, "_init_hit"}, o_hit, 1'b0);
      end
      if (cnt == ie_at + 1) check_val({nm, "_init_err_clear"}, o_err, 1'b0);
      @(negedge i_clk);
      cnt++;
    end
    i_ie = 1'b0;
    check_val({nm, "_ready_latency"}, cnt, 64);
  endtask

  initial begin
    logic [127:0] l0, l1, l2, l3, l4, lw;
    l0 = mk_line(32'hA0000000);
    l1 = mk_line(32'hB1000000);
    l2 = mk_line(32'hC2000000);
    l3 = mk_line(32'hD3000000);
    l4 = mk_line(32'hE4000000);

    // Install attempted during the sweep is flagged and dropped.
    reset_and_sweep("sweep0", 10, -1);
    cyc("noinst", 0, 0, 32'h000, 0, 0, 0, 0, 0, 1, 0, 0);

    cyc("ins_a", 0, 0, 32'h100, 1, 32'h000, l0, 0, 0, 0, 0, 0);
    cyc("rd_w2", 0, 0, 32'h008, 0, 0, 0, 1, 0, 1, 1, l0);

    lw = set_word(l0, 2, 32'h12345678);
    cyc("wr_byp", 1, 32'h12345678, 32'h008, 0, 0, 0, 1, 0, 1, 1, lw);
    cyc("wr_rd", 0, 0, 32'h004, 0, 0, 0, 1, 0, 1, 1, lw);

    // LRU: 0x000 touched after 0x400, so 0x800 evicts 0x400.
    reset_and_sweep("sweep1", -1, -1);
    cyc("lru_i0", 0, 0, 32'h100, 1, 32'h000, l0, 0, 0, 0, 0, 0);
    cyc("lru_i1", 0, 0, 32'h100, 1, 32'h400, l1, 0, 0, 0, 0, 0);
    cyc("lru_r0", 0, 0, 32'h000, 0, 0, 0, 1, 0, 1, 1, l0);
    cyc("lru_i2", 0, 0, 32'h100, 1, 32'h800, l2, 0, 0, 0, 0, 0);
    cyc("lru_r400", 0, 0, 32'h400, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("lru_r000", 0, 0, 32'h000, 0, 0, 0, 1, 0, 1, 1, l0);
    cyc("lru_r800", 0, 0, 32'h800, 0, 0, 0, 1, 0, 1, 1, l2);

    // Write miss is not allocated; mid-sweep reset restarts the sweep.
    reset_and_sweep("sweep2", -1, 20);
    cyc("wmiss", 1, 32'hDEADBEEF, 32'h404, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("wmiss_ins", 0, 0, 32'h100, 1, 32'h400, l1, 0, 0, 0, 0, 0);
    cyc("wmiss_rd", 0, 0, 32'h404, 0, 0, 0, 1, 0, 1, 1, l1);

    cyc("ins_byp", 0, 0, 32'h00C, 1, 32'h000, l3, 0, 0, 1, 1, l3);
    cyc("ins_byp_rd", 0, 0, 32'h00C, 0, 0, 0, 1, 0, 1, 1, l3);

    cyc("we_ie", 1, 32'hDEADBEEF, 32'h404, 1, 32'h400, l4, 1, 1, 1, 1, l4);
    cyc("we_ie_rd", 0, 0, 32'h404, 0, 0, 0, 1, 0, 1, 1, l4);

    // Reset from READY invalidates everything.
    reset_and_sweep("sweep3", -1, -1);
    cyc("post_rst", 0, 0, 32'h404, 0, 0, 0, 0, 0, 1, 0, 0);

    repeat (2) @(negedge i_clk);
    check_val("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
